alu_op_sequencer: RTL and testbench

- Initiator side of the ALU op interface: converts one job descriptor (input word count, output word count) into an ordered stream of alu_op commands for the ALU datapath.
- Emits GET_WORD_IN once per input word, MUX_WORD_OUT for every output word except the final one, and LAST_WORD_OUT for the final output word, each over a valid/ready handshake.
- Sits between the job scheduler and the ALU word datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_counter.sv | 33 +++
 rtl/alu_op_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU op interface and its sequencer.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 4'b0000;

  // One-hot op codes driven towards the ALU word datapath.
  typedef enum logic [ALU_OP_W-1:0] {
    GET_WORD_IN   = 4'b0001,
    MUX_WORD_OUT  = 4'b0010,
    LAST_WORD_OUT = 4'b0100
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET,
    ST_MUX,
    ST_LAST,
    ST_DONE
  } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_counter.sv
// Loadable down-counter; o_tc marks the last op of the current phase.
module alu_seq_counter #(
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [W_CNT-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  localparam logic [W_CNT-1:0] ONE = W_CNT'(1);

  logic [W_CNT-1:0] r_count;

  // Clear wins over load, load wins over decrement; never decrements below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Turns one job descriptor (input/output word counts) into an ordered
// stream of GET / MUX / LAST ops towards the ALU word datapath.
//
// state   | meaning
// IDLE    | waiting for a job, job_ready high
// GET     | issuing GET_WORD_IN, index 0..n_in-1
// MUX     | issuing MUX_WORD_OUT, index 0..n_out_eff-2
// LAST    | issuing LAST_WORD_OUT, index n_out_eff-1
// DONE    | one-cycle done pulse, then back to IDLE
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W_CNT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [W_CNT-1:0]    job_n_in,
  input  logic [W_CNT-1:0]    job_n_out,
  input  logic                abort,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [ALU_OP_W-1:0] op,
  output logic [W_CNT-1:0]    op_index,
  output logic                busy,
  output logic                done
);

  localparam logic [W_CNT-1:0] ONE = W_CNT'(1);
  localparam logic [W_CNT-1:0] TWO = W_CNT'(2);

  alu_seq_state_t      r_state;
  alu_seq_state_t      w_state_nxt;
  logic                r_op_valid;
  logic                w_op_valid_nxt;
  logic [ALU_OP_W-1:0] r_op;
  logic [ALU_OP_W-1:0] w_op_nxt;
  logic [W_CNT-1:0]    r_op_index;
  logic [W_CNT-1:0]    w_op_index_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_job_ready;
  logic                w_job_ready_nxt;
  logic [W_CNT-1:0]    r_n_out_eff;
  logic [W_CNT-1:0]    w_n_out_eff_nxt;

  logic                w_hs;
  logic                w_accept;
  logic [W_CNT-1:0]    w_job_n_out_eff;
  logic                w_cnt_clear;
  logic                w_cnt_load;
  logic [W_CNT-1:0]    w_cnt_load_val;
  logic                w_cnt_dec;
  logic                w_cnt_tc;

  assign w_hs            = r_op_valid && op_ready;
  assign w_accept        = (r_state == ST_IDLE) && r_job_ready && job_valid;
  assign w_job_n_out_eff = (job_n_out == '0) ? ONE : job_n_out;

  // Remaining ops in the current phase; loaded with (phase length - 1)
  // so the terminal flag is a compare against zero and nothing can wrap.
  alu_seq_counter #(
    .W_CNT (W_CNT)
  ) u_remain (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_cnt_clear),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_tc       (w_cnt_tc)
  );

  // Next-state and next-output decode; all outputs leave through registers.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_valid_nxt  = r_op_valid;
    w_op_nxt        = r_op;
    w_op_index_nxt  = r_op_index;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_job_ready_nxt = r_job_ready;
    w_n_out_eff_nxt = r_n_out_eff;
    w_cnt_clear     = 1'b0;
    w_cnt_load      = 1'b0;
    w_cnt_load_val  = '0;
    w_cnt_dec       = 1'b0;

    if (abort && (r_state != ST_IDLE)) begin
      // Abort beats a same-cycle handshake: that op is treated as never issued.
      w_state_nxt     = ST_IDLE;
      w_op_valid_nxt  = 1'b0;
      w_op_nxt        = ALU_OP_NOP;
      w_op_index_nxt  = '0;
      w_busy_nxt      = 1'b0;
      w_job_ready_nxt = 1'b1;
      w_n_out_eff_nxt = '0;
      w_cnt_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_job_ready_nxt = 1'b1;
          if (w_accept) begin
            w_job_ready_nxt = 1'b0;
            w_busy_nxt      = 1'b1;
            w_op_valid_nxt  = 1'b1;
            w_op_index_nxt  = '0;
            w_n_out_eff_nxt = w_job_n_out_eff;
            if (job_n_in != '0) begin
              w_state_nxt    = ST_GET;
              w_op_nxt       = GET_WORD_IN;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = job_n_in - ONE;
            end else if (w_job_n_out_eff > ONE) begin
              w_state_nxt    = ST_MUX;
              w_op_nxt       = MUX_WORD_OUT;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = w_job_n_out_eff - TWO;
            end else begin
              w_state_nxt    = ST_LAST;
              w_op_nxt       = LAST_WORD_OUT;
              w_op_index_nxt = w_job_n_out_eff - ONE;
            end
          end
        end

        ST_GET: begin
          if (w_hs) begin
            if (w_cnt_tc) begin
              w_op_index_nxt = '0;
              if (r_n_out_eff > ONE) begin
                w_state_nxt    = ST_MUX;
                w_op_nxt       = MUX_WORD_OUT;
                w_cnt_load     = 1'b1;
                w_cnt_load_val = r_n_out_eff - TWO;
              end else begin
                w_state_nxt    = ST_LAST;
                w_op_nxt       = LAST_WORD_OUT;
                w_op_index_nxt = r_n_out_eff - ONE;
              end
            end else begin
              w_op_index_nxt = r_op_index + ONE;
              w_cnt_dec      = 1'b1;
            end
          end
        end

        ST_MUX: begin
          if (w_hs) begin
            if (w_cnt_tc) begin
              w_state_nxt    = ST_LAST;
              w_op_nxt       = LAST_WORD_OUT;
              w_op_index_nxt = r_n_out_eff - ONE;
            end else begin
              w_op_index_nxt = r_op_index + ONE;
              w_cnt_dec      = 1'b1;
            end
          end
        end

        ST_LAST: begin
          if (w_hs) begin
            w_state_nxt    = ST_DONE;
            w_op_valid_nxt = 1'b0;
            w_op_nxt       = ALU_OP_NOP;
            w_op_index_nxt = '0;
            w_done_nxt     = 1'b1;
          end
        end

        ST_DONE: begin
          w_state_nxt     = ST_IDLE;
          w_busy_nxt      = 1'b0;
          w_job_ready_nxt = 1'b1;
        end

        default: begin
          w_state_nxt     = ST_IDLE;
          w_op_valid_nxt  = 1'b0;
          w_op_nxt        = ALU_OP_NOP;
          w_op_index_nxt  = '0;
          w_busy_nxt      = 1'b0;
          w_job_ready_nxt = 1'b1;
          w_cnt_clear     = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; job_ready comes up one clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op_valid  <= 1'b0;
      r_op        <= ALU_OP_NOP;
      r_op_index  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_job_ready <= 1'b0;
      r_n_out_eff <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_op        <= w_op_nxt;
      r_op_index  <= w_op_index_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_job_ready <= w_job_ready_nxt;
      r_n_out_eff <= w_n_out_eff_nxt;
    end
  end

  assign job_ready = r_job_ready;
  assign op_valid  = r_op_valid;
  assign op        = r_op;
  assign op_index  = r_op_index;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table of jobs plus hand-written
// abort and mid-job reset sequences, with an expected-op scoreboard.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W_CNT = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                job_valid;
  logic                job_ready;
  logic [W_CNT-1:0]    job_n_in;
  logic [W_CNT-1:0]    job_n_out;
  logic                abort;
  logic                op_valid;
  logic                op_ready;
  logic [ALU_OP_W-1:0] op;
  logic [W_CNT-1:0]    op_index;
  logic                busy;
  logic                done;

  alu_op_sequencer #(.W_CNT(W_CNT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_n_in  (job_n_in),
    .job_n_out (job_n_out),
    .abort     (abort),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .op_index  (op_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_in;
    int n_out;
    int mode;      // 0: ready held high, 1: random ready, 2: fixed stall pattern
    int ab;        // abort raised in the acceptance cycle (IDLE, must be ignored)
    int exp_ops;
    int exp_done;  // cycle of done pulse counted from first op cycle, -1 = not checked
  } vec_t;

  typedef struct {
    logic [ALU_OP_W-1:0] op;
    int                  idx;
  } exp_t;

  localparam int N_VEC = 10;

  vec_t        vecs [N_VEC];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [3:0]  prev_op = '0;
  logic [3:0]  prev_idx = '0;
  logic [7:0]  pat = 8'b1111_0100;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Called once per negedge: hold rule, NOP when idle, done width, scoreboard.
  task automatic mon();
    exp_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("hold_valid", int'(op_valid), 1);
      check("hold_op", int'(op), int'(prev_op));
      check("hold_idx", int'(op_index), int'(prev_idx));
    end
    if (!op_valid) check("nop_when_invalid", int'(op), int'(ALU_OP_NOP));
    if (done) begin
      check("done_width", int'(prev_done), 0);
      done_cnt++;
    end
    if (op_valid && op_ready && !abort) begin
      acc_cnt++;
      check("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("op_code", int'(op), int'(e.op));
        check("op_index", int'(op_index), e.idx);
      end
    end
    prev_stall = op_valid && !op_ready && !abort;
    prev_op    = op;
    prev_idx   = op_index;
    prev_done  = done;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    check("rst_job_ready", int'(job_ready), 0);
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_op", int'(op), int'(ALU_OP_NOP));
    check("rst_op_index", int'(op_index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
  endtask

  task automatic push_op(input logic [ALU_OP_W-1:0] o, input int i);
    exp_t e;
    e.op  = o;
    e.idx = i;
    sb.push_back(e);
  endtask

  task automatic push_job(input int n_in, input int n_out);
    int eff;
    eff = (n_out == 0) ? 1 : n_out;
    for (int i = 0; i < n_in; i++) push_op(GET_WORD_IN, i);
    for (int j = 0; j < eff - 1; j++) push_op(MUX_WORD_OUT, j);
    push_op(LAST_WORD_OUT, eff - 1);
  endtask

  task automatic wait_ready();
    for (int w = 0; w < 50; w++) begin
      if (job_ready) break;
      step();
      tick();
    end
    check("job_ready_wait", int'(job_ready), 1);
  endtask

  task automatic run_job(input vec_t v);
    int acc0, dc0, got_c;
    bit got;
    wait_ready();
    push_job(v.n_in, v.n_out);
    acc0 = acc_cnt;
    dc0  = done_cnt;
    step();
    job_valid = 1'b1;
    job_n_in  = W_CNT'(v.n_in);
    job_n_out = W_CNT'(v.n_out);
    abort     = (v.ab != 0);
    tick();
    step();
    job_valid = 1'b0;
    abort     = 1'b0;
    got   = 1'b0;
    got_c = -1;
    for (int c = 0; c < 400; c++) begin
      case (v.mode)
        0:       op_ready = 1'b1;
        1:       op_ready = 1'($urandom_range(0, 1));
        default: op_ready = (c < 8) ? pat[c] : 1'b1;
      endcase
      tick();
      if (done) begin
        got   = 1'b1;
        got_c = c;
        break;
      end
      step();
    end
    check("done_seen", int'(got), 1);
    if (got) begin
      if (v.exp_done >= 0) check("done_cycle", got_c, v.exp_done);
      check("ops_issued", acc_cnt - acc0, v.exp_ops);
      check("done_job_ready", int'(job_ready), 0);
      check("done_busy", int'(busy), 1);
      check("sb_drained", sb.size(), 0);
      step();
      tick();
      check("idle_job_ready", int'(job_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("done_pulses", done_cnt - dc0, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc0;
    vec_t v;

    vecs[0] = '{3,  2,  0, 0, 5,  5};
    vecs[1] = '{0,  0,  0, 0, 1,  1};
    vecs[2] = '{0,  3,  0, 0, 3,  3};
    vecs[3] = '{1,  1,  0, 1, 2,  2};
    vecs[4] = '{5,  0,  0, 0, 6,  6};
    vecs[5] = '{15, 15, 0, 0, 30, 30};
    vecs[6] = '{2,  1,  2, 0, 3,  6};
    vecs[7] = '{15, 0,  1, 0, 16, -1};
    vecs[8] = '{4,  6,  1, 0, 10, -1};
    vecs[9] = '{0,  15, 1, 0, 15, -1};

    reset_n   = 1'b0;
    job_valid = 1'b0;
    job_n_in  = '0;
    job_n_out = '0;
    abort     = 1'b0;
    op_ready  = 1'b0;

    @(negedge clk);
    chk_reset();
    #1 reset_n = 1'b1;
    step();
    tick();
    check("post_rst_job_ready", int'(job_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    for (int k = 0; k < N_VEC; k++) begin
      run_job(vecs[k]);
    end

    // Abort on the handshake of MUX(1) in an n_in=1, n_out=4 job.
    wait_ready();
    push_op(GET_WORD_IN, 0);
    push_op(MUX_WORD_OUT, 0);
    dc0 = done_cnt;
    step();
    job_valid = 1'b1;
    job_n_in  = W_CNT'(1);
    job_n_out = W_CNT'(4);
    tick();
    step();
    job_valid = 1'b0;
    op_ready  = 1'b1;
    tick();
    step();
    job_valid = 1'b1;
    job_n_in  = W_CNT'(7);
    tick();
    check("busy_job_ready", int'(job_ready), 0);
    step();
    job_valid = 1'b0;
    abort     = 1'b1;
    tick();
    check("abort_pre_op", int'(op), int'(MUX_WORD_OUT));
    check("abort_pre_idx", int'(op_index), 1);
    step();
    abort = 1'b0;
    tick();
    check("abort_op_valid", int'(op_valid), 0);
    check("abort_op", int'(op), int'(ALU_OP_NOP));
    check("abort_idx", int'(op_index), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_job_ready", int'(job_ready), 1);
    check("abort_sb", sb.size(), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      tick();
    end
    check("abort_no_done", done_cnt - dc0, 0);
    v = '{1, 1, 0, 0, 2, 2};
    run_job(v);

    // Reset pulled low for one clock while GET(5) of an n_in=10 job is on the bus.
    wait_ready();
    push_job(10, 2);
    dc0 = done_cnt;
    step();
    job_valid = 1'b1;
    job_n_in  = W_CNT'(10);
    job_n_out = W_CNT'(2);
    tick();
    step();
    job_valid = 1'b0;
    op_ready  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      step();
    end
    @(negedge clk);
    check("rst_pre_op", int'(op), int'(GET_WORD_IN));
    check("rst_pre_idx", int'(op_index), 5);
    #1 reset_n = 1'b0;
    #1 chk_reset();
    sb.delete();
    @(negedge clk);
    chk_reset();
    #1 reset_n = 1'b1;
    check("rst_no_done", done_cnt - dc0, 0);
    v = '{3, 1, 0, 0, 4, 4};
    run_job(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
